mc_model_mp: RTL

- Parametrised multi-port successor to the single-port dummy memory-controller model used in PHOLD benches.
- Presents NUM_PORTS independent Convey-style MC request/response channels backed by one shared word RAM.
- Features: per-port input/output buffering, round-robin RAM arbitration, configurable fixed access latency, credit-limited outstanding requests, and stall/skid flow control.
- Sits between phold (or any multi-core DUT) and the bench, so memory contention and latency become measurable.

---
 rtl/mc_model_mp.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_model_mp.sv
// mc_model_mp: NUM_PORTS Convey-style MC request/response channels over one
// shared 64-bit word RAM, with round-robin arbitration, fixed access latency,
// and credits that guarantee the output FIFOs never overflow.
// Build macro MC_MODEL_RAND_STALL_EN: a 16-bit LFSR suppresses about 25% of
// the arbitration grants to emulate DRAM contention.
module mc_model_mp #(
  parameter int NUM_PORTS       = 4,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int RAM_DEPTH       = 512,
  parameter int LATENCY         = 4,
  parameter int IN_FIFO_DEPTH   = 8,
  parameter int OUT_FIFO_DEPTH  = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 mc_rq_vld,
  input  logic [3*NUM_PORTS-1:0]               mc_rq_cmd,
  input  logic [4*NUM_PORTS-1:0]               mc_rq_scmd,
  input  logic [48*NUM_PORTS-1:0]              mc_rq_vadr,
  input  logic [2*NUM_PORTS-1:0]               mc_rq_size,
  input  logic [MC_RTNCTL_WIDTH*NUM_PORTS-1:0] mc_rq_rtnctl,
  input  logic [64*NUM_PORTS-1:0]              mc_rq_data,
  input  logic [NUM_PORTS-1:0]                 mc_rq_flush,
  output logic [NUM_PORTS-1:0]                 mc_rq_stall,
  output logic [NUM_PORTS-1:0]                 mc_rs_vld,
  output logic [3*NUM_PORTS-1:0]               mc_rs_cmd,
  output logic [4*NUM_PORTS-1:0]               mc_rs_scmd,
  output logic [MC_RTNCTL_WIDTH*NUM_PORTS-1:0] mc_rs_rtnctl,
  output logic [64*NUM_PORTS-1:0]              mc_rs_data,
  input  logic [NUM_PORTS-1:0]                 mc_rs_stall,
  output logic                                 err
);

  localparam int AW  = $clog2(RAM_DEPTH);
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IAW = $clog2(IN_FIFO_DEPTH);
  localparam int OAW = $clog2(OUT_FIFO_DEPTH);
  localparam int CW  = OAW + 1;
  localparam logic [IAW:0] IN_FULL  = (IAW+1)'(IN_FIFO_DEPTH);
  localparam logic [IAW:0] IN_HIGH  = (IAW+1)'(IN_FIFO_DEPTH - 2);
  localparam logic [CW-1:0] CRED_MAX = CW'(OUT_FIFO_DEPTH);

  typedef struct packed {
    logic                       rd;
    logic [3:0]                 scmd;
    logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
    logic [AW-1:0]              idx;
    logic [63:0]                data;
  } rq_t;

  typedef struct packed {
    logic                       rd;
    logic [3:0]                 scmd;
    logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
    logic [63:0]                data;
  } rs_t;

  rq_t            in_mem [NUM_PORTS][IN_FIFO_DEPTH];
  logic [IAW-1:0] in_wp [NUM_PORTS];
  logic [IAW-1:0] in_rp [NUM_PORTS];
  logic [IAW:0]   in_cnt [NUM_PORTS];
  logic [IAW:0]   in_cnt_nxt [NUM_PORTS];
  rq_t            rq_in [NUM_PORTS];
  logic [NUM_PORTS-1:0] push, bad;

  logic [CW-1:0]  credit [NUM_PORTS];
  logic [PW-1:0]  rr_ptr;
  logic [NUM_PORTS-1:0] grant;
  logic           gnt_any;
  logic [PW-1:0]  gnt_port;
  logic           arb_en;

  logic           g_vld;
  logic [PW-1:0]  g_port;
  rq_t            g_rq;
  logic [63:0]    ram [RAM_DEPTH];

  logic           d_vld [LATENCY];
  logic [PW-1:0]  d_port [LATENCY];
  rs_t            d_rs [LATENCY];

  rs_t            out_mem [NUM_PORTS][OUT_FIFO_DEPTH];
  logic [OAW-1:0] out_wp [NUM_PORTS];
  logic [OAW-1:0] out_rp [NUM_PORTS];
  logic [OAW:0]   out_cnt [NUM_PORTS];
  rs_t            out_head [NUM_PORTS];
  logic [NUM_PORTS-1:0] ow_en, rs_pop;

  // Only the word-index bits of vadr matter; size is meaningless here.
  logic unused_bits;
  assign unused_bits = ^{mc_rq_size, mc_rq_vadr};

`ifdef MC_MODEL_RAND_STALL_EN
  logic [15:0] lfsr;
  // Contention LFSR, x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign arb_en = (lfsr[1:0] != 2'b00);
`else
  assign arb_en = 1'b1;
`endif

  // Accept decode: legal requests push, flushes vanish, illegal cmd or full FIFO flags err.
  always_comb begin
    push = '0;
    bad  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rq_in[p] = '{rd:     (mc_rq_cmd[3*p +: 3] == 3'd1),
                   scmd:   mc_rq_scmd[4*p +: 4],
                   rtnctl: mc_rq_rtnctl[MC_RTNCTL_WIDTH*p +: MC_RTNCTL_WIDTH],
                   idx:    mc_rq_vadr[48*p+3 +: AW],
                   data:   mc_rq_data[64*p +: 64]};
      if (mc_rq_vld[p] && !mc_rq_flush[p]) begin
        if (mc_rq_cmd[3*p +: 3] != 3'd1 && mc_rq_cmd[3*p +: 3] != 3'd2) bad[p] = 1'b1;
        else if (in_cnt[p] == IN_FULL)                                bad[p] = 1'b1;
        else                                                          push[p] = 1'b1;
      end
    end
  end

  // Round-robin pick: first eligible port at or after rr_ptr, then wrap.
  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_port = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (!gnt_any && in_cnt[p] != '0 && credit[p] != '0 && PW'(p) >= rr_ptr) begin
        gnt_any  = 1'b1;
        gnt_port = PW'(p);
      end
    for (int p = 0; p < NUM_PORTS; p++)
      if (!gnt_any && in_cnt[p] != '0 && credit[p] != '0) begin
        gnt_any  = 1'b1;
        gnt_port = PW'(p);
      end
    if (!arb_en) gnt_any = 1'b0;
    if (gnt_any) grant[gnt_port] = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++)
      in_cnt_nxt[p] = in_cnt[p] + (IAW+1)'(push[p]) - (IAW+1)'(grant[p]);
  end

  // Request FIFO storage.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++)
      if (push[p]) in_mem[p][in_wp[p]] <= rq_in[p];
  end

  // Request FIFO pointers, skid stall, credits, RR pointer and sticky err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        in_wp[p]  <= '0;
        in_rp[p]  <= '0;
        in_cnt[p] <= '0;
        credit[p] <= CRED_MAX;
      end
      mc_rq_stall <= '0;
      rr_ptr      <= '0;
      err         <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p])  in_wp[p] <= in_wp[p] + IAW'(1);
        if (grant[p]) in_rp[p] <= in_rp[p] + IAW'(1);
        in_cnt[p]      <= in_cnt_nxt[p];
        mc_rq_stall[p] <= (in_cnt_nxt[p] >= IN_HIGH);
        if (grant[p] && !rs_pop[p])      credit[p] <= credit[p] - CW'(1);
        else if (!grant[p] && rs_pop[p]) credit[p] <= credit[p] + CW'(1);
      end
      if (gnt_any) rr_ptr <= (gnt_port == PW'(NUM_PORTS-1)) ? '0 : gnt_port + PW'(1);
      if (|bad) err <= 1'b1;
    end
  end

  // RAM write in the access cycle; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (g_vld && !g_rq.rd) ram[g_rq.idx] <= g_rq.data;
  end

  // Grant register, RAM read into stage 0, then the fixed-latency delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_vld  <= 1'b0;
      g_port <= '0;
      g_rq   <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        d_vld[s]  <= 1'b0;
        d_port[s] <= '0;
        d_rs[s]   <= '0;
      end
    end else begin
      g_vld <= gnt_any;
      if (gnt_any) begin
        g_port <= gnt_port;
        g_rq   <= in_mem[gnt_port][in_rp[gnt_port]];
      end
      d_vld[0]  <= g_vld;
      d_port[0] <= g_port;
      d_rs[0]   <= '{rd: g_rq.rd, scmd: g_rq.scmd, rtnctl: g_rq.rtnctl,
                     data: g_rq.rd ? ram[g_rq.idx] : 64'd0};
      for (int s = 1; s < LATENCY; s++) begin
        d_vld[s]  <= d_vld[s-1];
        d_port[s] <= d_port[s-1];
        d_rs[s]   <= d_rs[s-1];
      end
    end
  end

  // Response FIFO storage; credits guarantee a free slot on every write.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++)
      if (ow_en[p]) out_mem[p][out_wp[p]] <= d_rs[LATENCY-1];
  end

  // Response FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_wp[p]  <= '0;
        out_rp[p]  <= '0;
        out_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (ow_en[p])  out_wp[p] <= out_wp[p] + OAW'(1);
        if (rs_pop[p]) out_rp[p] <= out_rp[p] + OAW'(1);
        out_cnt[p] <= out_cnt[p] + (OAW+1)'(ow_en[p]) - (OAW+1)'(rs_pop[p]);
      end
    end
  end

  // Response outputs from the FIFO head, forced to zero when empty.
  always_comb begin
    ow_en        = '0;
    rs_pop       = '0;
    mc_rs_vld    = '0;
    mc_rs_cmd    = '0;
    mc_rs_scmd   = '0;
    mc_rs_rtnctl = '0;
    mc_rs_data   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      ow_en[p]    = d_vld[LATENCY-1] && (d_port[LATENCY-1] == PW'(p));
      out_head[p] = out_mem[p][out_rp[p]];
      if (out_cnt[p] != '0) begin
        mc_rs_vld[p]                                       = 1'b1;
        rs_pop[p]                                          = !mc_rs_stall[p];
        mc_rs_cmd[3*p +: 3]                                = out_head[p].rd ? 3'd2 : 3'd3;
        mc_rs_scmd[4*p +: 4]                               = out_head[p].scmd;
        mc_rs_rtnctl[MC_RTNCTL_WIDTH*p +: MC_RTNCTL_WIDTH] = out_head[p].rtnctl;
        mc_rs_data[64*p +: 64]                             = out_head[p].data;
      end
    end
  end

endmodule
